// File: rtl/monitor_gray_pkg.sv
// ============================================================================
// monitor_gray_pkg : shared widths and FSM encoding for the Gray monitor
// Rev 1.0
// ============================================================================
`default_nettype none

package monitor_gray_pkg;

  localparam int GRAY_W        = 5;
  localparam int ERR_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACQUIRE = 2'b01,
    TRACK   = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/monitor_gray_gray_a_bin.sv
// ============================================================================
// monitor_gray_gray_a_bin : combinational Gray-to-binary decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module monitor_gray_gray_a_bin
  import monitor_gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

`default_nettype wire

// File: rtl/monitor_gray.sv
// ============================================================================
// monitor_gray : decodes a Gray counter bus and checks every step against
//                the counter's enable history; counts illegal steps.
// Rev 1.0
// ============================================================================
`default_nettype none

module monitor_gray
  import monitor_gray_pkg::*;
#(
  parameter int WIDTH     = GRAY_W,
  parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_in,
  input  logic [WIDTH-1:0]     gray_in,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 step_err,
  output logic                 wrap_pulse,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_exp;
  logic [WIDTH-1:0] r_prev_bin;
  logic             r_en_d;
  state_t           r_state;

  monitor_gray_gray_a_bin #(.WIDTH(WIDTH)) u_dec (
    .gray (gray_in),
    .bin  (w_dec)
  );

  // The counter moved at the previous edge only if enable was high there.
  assign w_exp = r_en_d ? r_prev_bin + 1'b1 : r_prev_bin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prev_bin <= '0;
      r_en_d     <= 1'b0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      step_err   <= 1'b0;
      wrap_pulse <= 1'b0;
      locked     <= 1'b0;
      err_count  <= '0;
    end else begin
      r_en_d     <= enable_in;
      bin_out    <= w_dec;
      r_prev_bin <= w_dec;
      step_err   <= 1'b0;
      wrap_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          bin_valid <= 1'b1;
          r_state   <= ACQUIRE;
        end
        ACQUIRE: begin
          locked  <= 1'b1;
          r_state <= TRACK;
        end
        TRACK: begin
          if (w_dec != w_exp) begin
            step_err <= 1'b1;
            locked   <= 1'b0;
            r_state  <= ACQUIRE;
            if (err_count != {ERR_CNT_W{1'b1}}) begin
              err_count <= err_count + 1'b1;
            end
          end else if ((r_prev_bin == {WIDTH{1'b1}}) && (w_dec == '0)) begin
            wrap_pulse <= 1'b1;
          end
        end
        default: begin
          locked  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
